// File: rtl/ram_io_responder.sv
// Byte-serial memory responder: 1-cycle read RAM, TX FIFO / RX port / sim-end flag IO window.
// RAM content starts undefined; write before reading.
module ram_io_responder #(
    parameter int ADDR_W     = 17,
    parameter int FIFO_DEPTH = 8,
    parameter     INIT_FILE  = "test.data"
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [31:0] data_addr,
    input  logic        data_wr,
    input  logic [7:0]  wr_byte,
    output logic [7:0]  rd_byte,
    output logic        io_buffer_full,
    output logic [7:0]  tx_byte,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_byte,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        sim_end
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] HIGH_C  = CNT_W'(FIFO_DEPTH - 2);
    localparam logic [17:0]      TX_ADDR  = 18'h30000;
    localparam logic [17:0]      END_ADDR = 18'h30004;

    logic [7:0] mem [2**ADDR_W];
    logic [7:0] fifo_q [FIFO_DEPTH];

    logic [7:0]       rd_byte_q, rd_byte_d, tx_byte_q, tx_byte_d;
    logic             tx_valid_q, full_q, rx_ready_q, sim_end_q, sim_end_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      prev_addr_q;
    logic             prev_wr_q;

    logic             io_sel, wr_cyc, rd_cyc, push, pop, push_ok, rx_first;
    logic [17:0]      io_off;
    logic [ADDR_W-1:0] idx;

    assign io_sel = (data_addr[17:16] == 2'b11);
    assign io_off = data_addr[17:0];
    assign idx    = data_addr[ADDR_W-1:0];
    assign wr_cyc = rdy && data_wr;
    assign rd_cyc = rdy && !data_wr;
    assign push   = wr_cyc && io_off == TX_ADDR;
    assign pop    = tx_valid_q && tx_ready;
    // A pop frees a slot in the same cycle, so a push into a full FIFO is accepted then.
    assign push_ok  = push && (count_q != DEPTH_C || pop);
    // Pop the RX byte only when the RX address is freshly presented.
    assign rx_first = rd_cyc && io_off == TX_ADDR && (data_addr != prev_addr_q || prev_wr_q);

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        rd_byte_d = rd_byte_q;
        sim_end_d = sim_end_q | (wr_cyc && io_off == END_ADDR);
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push_ok && !pop)      count_d = count_q + CNT_W'(1);
        else if (pop && !push_ok) count_d = count_q - CNT_W'(1);
        // The byte being written this edge is not in storage yet; forward it when it becomes head.
        tx_byte_d = (push_ok && wr_ptr_q == rd_ptr_d) ? wr_byte : fifo_q[rd_ptr_d];
        if (rd_cyc) begin
            if (!io_sel)                rd_byte_d = mem[idx];
            else if (io_off == TX_ADDR) rd_byte_d = rx_valid ? rx_byte : 8'h00;
            else                        rd_byte_d = 8'h00;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_cyc && !io_sel) mem[idx] <= wr_byte;
        if (push_ok) fifo_q[wr_ptr_q] <= wr_byte;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_byte_q   <= 8'h00;
            tx_byte_q   <= 8'h00;
            tx_valid_q  <= 1'b0;
            full_q      <= 1'b0;
            rx_ready_q  <= 1'b0;
            sim_end_q   <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            prev_addr_q <= '0;
            prev_wr_q   <= 1'b1;
        end else begin
            rd_byte_q  <= rd_byte_d;
            tx_byte_q  <= tx_byte_d;
            tx_valid_q <= (count_d != '0);
            full_q     <= (count_d >= HIGH_C);
            rx_ready_q <= rx_first;
            sim_end_q  <= sim_end_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            if (rdy) begin
                prev_addr_q <= data_addr;
                prev_wr_q   <= data_wr;
            end
        end
    end

    assign rd_byte        = rd_byte_q;
    assign tx_byte        = tx_byte_q;
    assign tx_valid       = tx_valid_q;
    assign io_buffer_full = full_q;
    assign rx_ready       = rx_ready_q;
    assign sim_end        = sim_end_q;
endmodule

// File: tb/tb_ram_io_responder.sv
// Bench for ram_io_responder: directed cases plus random traffic against a queue/array model.
module tb_ram_io_responder;
    localparam int ADDR_W = 17;
    localparam int DEPTH  = 8;

    logic        clk = 1'b0;
    logic        rst, rdy, data_wr, tx_ready, rx_valid;
    logic [31:0] data_addr;
    logic [7:0]  wr_byte, rx_byte;
    logic [7:0]  rd_byte, tx_byte;
    logic        io_buffer_full, tx_valid, rx_ready, sim_end;

    always #5 clk = ~clk;

    ram_io_responder #(.ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .data_addr(data_addr), .data_wr(data_wr),
        .wr_byte(wr_byte), .rd_byte(rd_byte), .io_buffer_full(io_buffer_full),
        .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_byte(rx_byte), .rx_valid(rx_valid), .rx_ready(rx_ready), .sim_end(sim_end)
    );

    // Reference model
    logic [7:0] ram_m [int];
    logic [7:0] txq [$];
    logic [7:0] e_rd, e_txb;
    bit         e_rd_chk, e_txb_chk, e_full, e_rxr, e_end;
    longint     last_rd;
    int         vecs = 0, errs = 0;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        bit pop, push, io;
        logic [17:0] off;
        int idx;
        if (rst) begin
            txq.delete();
            e_rd = 8'h00; e_rd_chk = 1; e_full = 0; e_rxr = 0; e_end = 0;
            e_txb = 8'h00; e_txb_chk = 1; last_rd = -1;
        end else begin
            io   = (data_addr[17:16] == 2'b11);
            off  = data_addr[17:0];
            idx  = int'(data_addr[ADDR_W-1:0]);
            pop  = (txq.size() != 0) && tx_ready;
            push = rdy && data_wr && off == 18'h30000;
            e_rxr = 0;
            if (pop) void'(txq.pop_front());
            if (push) begin
                if (txq.size() < DEPTH) txq.push_back(wr_byte);
                else $display("note: controller pushed into a full TX FIFO, byte dropped");
            end
            if (rdy) begin
                if (data_wr) begin
                    if (!io) ram_m[idx] = wr_byte;
                    else if (off == 18'h30004) e_end = 1;
                    last_rd = -1;
                end else begin
                    if (!io) begin
                        e_rd_chk = ram_m.exists(idx);
                        if (e_rd_chk) e_rd = ram_m[idx];
                    end else if (off == 18'h30000) begin
                        e_rd = rx_valid ? rx_byte : 8'h00; e_rd_chk = 1;
                        e_rxr = (longint'(data_addr) != last_rd);
                    end else begin
                        e_rd = 8'h00; e_rd_chk = 1;
                    end
                    last_rd = longint'(data_addr);
                end
            end
            e_full    = (txq.size() >= DEPTH - 2);
            e_txb_chk = (txq.size() != 0);
            if (e_txb_chk) e_txb = txq[0];
        end
        @(posedge clk); #1;
        if (e_rd_chk)  chk("rd_byte", rd_byte, e_rd);
        if (e_txb_chk) chk("tx_byte", tx_byte, e_txb);
        chk("tx_valid", tx_valid, txq.size() != 0);
        chk("io_buffer_full", io_buffer_full, e_full);
        chk("rx_ready", rx_ready, e_rxr);
        chk("sim_end", sim_end, e_end);
    endtask

    task automatic drive(bit w, logic [31:0] a, logic [7:0] d);
        data_wr = w; data_addr = a; wr_byte = d;
        step();
    endtask

    task automatic drain();
        data_wr = 0; data_addr = 32'h30008; tx_ready = 1;
        for (int i = 0; i < 20 && txq.size() != 0; i++) step();
        chk("drain_done", tx_valid, 1'b0);
    endtask

    initial begin
        int n;
        rst = 1; rdy = 1; data_wr = 0; data_addr = 0; wr_byte = 0;
        tx_ready = 0; rx_valid = 0; rx_byte = 0;
        step(); step();
        rst = 0;

        // RAM write then back-to-back reads
        drive(1, 32'h100, 8'h12); drive(1, 32'h101, 8'h34);
        drive(1, 32'h102, 8'h56); drive(1, 32'h103, 8'h78);
        drive(0, 32'h100, 0); chk("rd_100", rd_byte, 8'h12);
        drive(0, 32'h101, 0); chk("rd_101", rd_byte, 8'h34);
        drive(0, 32'h102, 0); chk("rd_102", rd_byte, 8'h56);
        drive(0, 32'h103, 0); chk("rd_103", rd_byte, 8'h78);

        // Address wrap
        drive(1, 32'h20005, 8'hAB);
        drive(0, 32'h00005, 0); chk("wrap_rd", rd_byte, 8'hAB);

        // TX FIFO high-water flag
        tx_ready = 0;
        for (int i = 0; i < 6; i++) begin
            drive(1, 32'h30000, 8'hA0 + 8'(i));
            if (i == 4) chk("full_after5", io_buffer_full, 1'b0);
        end
        chk("full_after6", io_buffer_full, 1'b1);
        drive(0, 32'h30008, 0);
        tx_ready = 1; drive(0, 32'h30008, 0);
        chk("full_drop_after_pop", io_buffer_full, 1'b0);
        drain();

        // Overfill (drop) then push and pop together while full
        tx_ready = 0;
        for (int i = 0; i < 9; i++) drive(1, 32'h30000, 8'hC0 + 8'(i));
        tx_ready = 1; drive(1, 32'h30000, 8'hD0);
        drain();

        // RX port: one pop per fresh address
        rx_valid = 1; rx_byte = 8'h41; n = 0;
        for (int i = 0; i < 3; i++) begin
            drive(0, 32'h30000, 0);
            if (rx_ready) n++;
            chk("rx_data", rd_byte, 8'h41);
        end
        chk("rx_pulses", n, 1);
        rx_valid = 0; drive(0, 32'h30000, 0); chk("rx_empty", rd_byte, 8'h00);

        // Sticky sim_end and reset with a push in flight
        drive(1, 32'h30004, 8'h01); chk("sim_end_set", sim_end, 1'b1);
        for (int i = 0; i < 10; i++) drive(0, 32'h0, 0);
        chk("sim_end_hold", sim_end, 1'b1);
        tx_ready = 0;
        drive(1, 32'h30000, 8'h11); drive(1, 32'h30000, 8'h22);
        rst = 1; drive(1, 32'h30000, 8'h33); rst = 0;
        chk("rst_sim_end", sim_end, 1'b0);
        chk("rst_tx_valid", tx_valid, 1'b0);

        // rdy low: no write/push, drain continues
        drive(1, 32'h200, 8'h3C);
        drive(1, 32'h30000, 8'h44); drive(1, 32'h30000, 8'h45);
        tx_ready = 1; rdy = 0;
        drive(1, 32'h200, 8'h55); drive(1, 32'h30000, 8'h66);
        rdy = 1;
        drive(0, 32'h200, 0); chk("rdy_lo_rd", rd_byte, 8'h3C);
        drain();

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            int r;
            logic [31:0] ra;
            rst = ($urandom_range(0, 149) == 0);
            rdy = ($urandom_range(0, 9) != 0);
            tx_ready = $urandom_range(0, 1);
            rx_valid = $urandom_range(0, 1);
            rx_byte  = 8'($urandom);
            ra = 32'h1000 + $urandom_range(0, 31);
            ra = ra | (32'($urandom_range(0, 1)) << 17) | (32'($urandom_range(0, 3)) << 20);
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2: drive(1, ra, 8'($urandom));
                3, 4, 5: drive(0, ra, 0);
                6: if (!e_full) drive(1, 32'h30000, 8'($urandom)); else drive(0, 32'h30004, 0);
                7: drive(0, 32'h30000, 0);
                8: drive($urandom_range(0, 1), 32'h3000C, 8'($urandom));
                default: begin data_wr = 0; step(); end
            endcase
        end
        rst = 0; rdy = 1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
